// File: rtl/rca_word_serial_ctrl.sv
// Word-serial wide adder/subtractor: one CHUNK-bit ripple-carry slice reused over
// OP_WIDTH/CHUNK cycles, LSB chunk first, with the inter-chunk carry held in a register.

module rca_chunk_adder #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    // Each full-adder stage owns its carry so the chain has no vector self-dependency.
    for (genvar i = 0; i < W; i++) begin : g_fa
        logic cin_i;
        logic cout_i;
        if (i == 0) begin : g_first
            assign cin_i = ci;
        end else begin : g_next
            assign cin_i = g_fa[i-1].cout_i;
        end
        assign s[i]   = a[i] ^ b[i] ^ cin_i;
        assign cout_i = (a[i] & b[i]) | (cin_i & (a[i] ^ b[i]));
    end

    assign co = g_fa[W-1].cout_i;
endmodule

module rca_word_serial_ctrl #(
    parameter int unsigned OP_WIDTH = 256,
    parameter int unsigned CHUNK    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] a,
    input  logic [OP_WIDTH-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_WIDTH-1:0] sum,
    output logic                cout,
    output logic                ovf
);
    localparam int unsigned NUM_CHUNKS = OP_WIDTH / CHUNK;
    localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned BASE_W     = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [OP_WIDTH-1:0] a_reg;
    logic [OP_WIDTH-1:0] b_reg;
    logic                carry;
    logic [IDX_W-1:0]    idx;

    logic [BASE_W-1:0]   base;
    logic [CHUNK-1:0]    a_chunk;
    logic [CHUNK-1:0]    b_chunk;
    logic [CHUNK-1:0]    s_chunk;
    logic                c_chunk;

    assign base    = BASE_W'(32'(idx) * CHUNK);
    assign a_chunk = a_reg[base +: CHUNK];
    assign b_chunk = b_reg[base +: CHUNK];

    rca_chunk_adder #(.W(CHUNK)) u_slice (
        .a  (a_chunk),
        .b  (b_chunk),
        .ci (carry),
        .s  (s_chunk),
        .co (c_chunk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // Subtraction is a + ~b + 1, so the +1 rides in on the initial carry.
                        a_reg    <= a;
                        b_reg    <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : cin;
                        idx      <= '0;
                        sum      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: CHUNK] <= s_chunk;
                    carry              <= c_chunk;
                    idx                <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout      <= c_chunk;
                        ovf       <= (a_chunk[CHUNK-1] == b_chunk[CHUNK-1]) &&
                                     (s_chunk[CHUNK-1] != a_chunk[CHUNK-1]);
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rca_word_serial_ctrl.sv
// Bench for rca_word_serial_ctrl: transaction-level arithmetic model with a per-cycle
// compare process, plus directed operations pinned by hand-computed results.

module tb_rca_word_serial_ctrl;
    localparam int unsigned W   = 256;
    localparam int unsigned CH  = 64;
    localparam int unsigned NCH = W / CH;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic         ovf;
    logic [W-1:0] sum;

    int checks   = 0;
    int failures = 0;

    rca_word_serial_ctrl #(.OP_WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum} from plain unsigned and signed arithmetic.
    function automatic logic [W+1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci, input logic s);
        logic [W-1:0]          r;
        logic [W:0]            wide;
        logic signed [W+1:0]   sr;
        logic                  co;
        logic                  ov;
        if (s) begin
            r  = x - y;
            co = (x >= y);
            sr = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y});
        end else begin
            wide = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            r    = wide[W-1:0];
            co   = wide[W];
            sr   = $signed({{2{x[W-1]}}, x}) + $signed({{2{y[W-1]}}, y})
                 + $signed({{(W+1){1'b0}}, ci});
        end
        // The exact signed result fits in W+1 bits; it is representable in W bits
        // only when its top two bits agree.
        ov = (sr[W] != sr[W-1]);
        return {ov, co, r};
    endfunction

    // Transaction model: accepted op -> NCH busy edges -> result held until consumed.
    bit           m_busy;
    bit           m_valid;
    int           m_cnt;
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_ovf;
    logic [W+1:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 0;
            m_valid = 0;
            m_cnt   = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
            m_pend  = '0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == NCH) begin
                m_busy  = 0;
                m_valid = 1;
                {m_ovf, m_cout, m_sum} = m_pend;
            end
        end else if (in_valid) begin
            m_pend = golden(a, b, cin, sub);
            m_busy = 1;
            m_cnt  = 0;
        end
    end

    // Result outputs are only meaningful when no operation is in flight.
    always @(negedge clk) begin
        chk1("model_in_ready", in_ready, !m_busy && !m_valid);
        chk1("model_out_valid", out_valid, m_valid);
        if (!m_busy) begin
            chkw("model_sum", sum, m_sum);
            chk1("model_cout", cout, m_cout);
            chk1("model_ovf", ovf, m_ovf);
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s, input logic [W-1:0] exp_sum,
                          input logic exp_co, input logic exp_ov);
        bit ok;
        int lat;
        a = x; b = y; cin = ci; sub = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_ready(ok);
        chk1({name, "_accept"}, ok, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(lat);
        chki({name, "_latency"}, lat, 4);
        chkw({name, "_sum"}, sum, exp_sum);
        chk1({name, "_cout"}, cout, exp_co);
        chk1({name, "_ovf"}, ovf, exp_ov);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] all1;
        logic [W-1:0] smax;
        logic [W-1:0] smin;
        bit           ok;
        int           lat;

        all1 = '1;
        smax = {1'b0, {(W-1){1'b1}}};
        smin = {1'b1, {(W-1){1'b0}}};

        // Reset held with a pending request: nothing may start.
        in_valid = 1'b1; a = W'(5); b = W'(6);
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk1("rst_in_ready", in_ready, 1'b1);
            chk1("rst_out_valid", out_valid, 1'b0);
            chkw("rst_sum", sum, '0);
            chk1("rst_cout", cout, 1'b0);
            chk1("rst_ovf", ovf, 1'b0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk1("idle_after_rst", in_ready, 1'b1);

        run_op("ripple", all1, W'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0);
        run_op("borrow", W'(5), W'(7), 1'b1, 1'b1, ~W'(1), 1'b0, 1'b0);
        run_op("ovf_add", smax, W'(1), 1'b0, 1'b0, smin, 1'b0, 1'b1);
        run_op("ovf_sub", smin, W'(1), 1'b0, 1'b1, smax, 1'b1, 1'b1);
        run_op("chunk_carry", W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, 1'b0,
               W'(1) << 64, 1'b0, 1'b0);
        run_op("cin_add", W'(3), W'(4), 1'b1, 1'b0, W'(8), 1'b0, 1'b0);
        run_op("neg_neg", smin, smin, 1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Backpressure: result held while a new request waits at the input.
        a = W'(3); b = W'(4); cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        wait_ready(ok);
        chk1("bp_accept", ok, 1'b1);
        @(posedge clk);
        #1 a = W'(100); b = W'(23);
        wait_result(lat);
        chki("bp_latency", lat, 4);
        chkw("bp_sum_first", sum, W'(7));
        repeat (10) begin
            @(negedge clk);
            chk1("bp_hold_valid", out_valid, 1'b1);
            chkw("bp_hold_sum", sum, W'(7));
            chk1("bp_hold_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk1("bp_ready_after_pop", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        wait_result(lat);
        chki("bp2_latency", lat, 4);
        chkw("bp2_sum", sum, W'(123));
        @(posedge clk);
        #1;

        // Abort after two RUN cycles.
        a = all1; b = W'(1); cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        wait_ready(ok);
        chk1("abort_accept", ok, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_out_valid", out_valid, 1'b0);
        chkw("abort_sum", sum, '0);
        chk1("abort_cout", cout, 1'b0);
        chk1("abort_ovf", ovf, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("after_abort", W'(10), W'(20), 1'b0, 1'b0, W'(30), 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
